ir_scan_seq: RTL

IR_SCAN_SEQ -- requirements
Module: ir_scan_seq

---
 rtl/ir_scan_pkg.sv | 36 +++
 rtl/ir_scan_seq_settle_tmr.sv | 27 ++
 rtl/ir_scan_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ir_scan_pkg.sv
// Shared definitions for the IR sensor scan sequencer: state encoding and
// width derivations used by the top level and the bench.
package ir_scan_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        CNV_R  = 3'd2,
        WAIT_R = 3'd3,
        CNV_L  = 3'd4,
        WAIT_L = 3'd5,
        NEXT   = 3'd6,
        DONE   = 3'd7
    } state_t;

    function automatic int ch_width(input int pairs);
        int w;
        w = $clog2(2 * pairs);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int err_width(input int res_w, input int pairs);
        return res_w + pairs + 1;
    endfunction

    // Index of the lowest set bit; the loop runs high-to-low so the last hit wins.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (v[7 - i]) idx = 3'(7 - i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ir_scan_seq_settle_tmr.sv
// Emitter settle timer: loads the terminal count on start and flags the
// final cycle of the settle window.
module settle_tmr #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] term,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= term;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = (cnt == CNT_W'(1));

endmodule

// File: rtl/ir_scan_seq.sv
// IR sensor pair scan sequencer: settles each enabled pair, converts right
// then left, and accumulates (R - L) << pair into a signed sweep error.
module ir_scan_seq
    import ir_scan_pkg::*;
#(
    parameter  int NUM_PAIRS  = 4,
    parameter  int RES_W      = 12,
    parameter  int SETTLE_CNT = 4095,
    localparam int CH_W       = ir_scan_pkg::ch_width(NUM_PAIRS),
    localparam int ERR_W      = ir_scan_pkg::err_width(RES_W, NUM_PAIRS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go,
    input  logic [NUM_PAIRS-1:0]    pair_mask,
    output logic                    strt_cnv,
    output logic [CH_W-1:0]         chnnl,
    input  logic                    cnv_cmplt,
    input  logic [RES_W-1:0]        A2D_res,
    output logic [NUM_PAIRS-1:0]    ir_en,
    output logic signed [ERR_W-1:0] error,
    output logic                    err_vld,
    output logic                    busy
);

    state_t                  state;
    logic [NUM_PAIRS-1:0]    rem;
    logic [2:0]              idx;
    logic [RES_W-1:0]        r_val;
    logic signed [ERR_W-1:0] acc;
    logic signed [RES_W:0]   diff;
    logic signed [ERR_W-1:0] diff_ext;
    logic                    go_ok;
    logic                    tmr_start;
    logic                    tmr_exp;
    logic                    pair_active;
    logic                    left_side;

    // err_vld keeps busy high for one IDLE cycle, so go is also gated on it.
    assign go_ok     = go && (state == IDLE) && !err_vld;
    assign tmr_start = (go_ok && (pair_mask != '0)) || ((state == NEXT) && (rem != '0));

    assign diff     = $signed({1'b0, r_val}) - $signed({1'b0, A2D_res});
    assign diff_ext = ERR_W'(diff);

    settle_tmr #(
        .CNT_W(16)
    ) u_settle_tmr (
        .clk    (clk),
        .rst    (rst),
        .start  (tmr_start),
        .term   (16'(SETTLE_CNT)),
        .expired(tmr_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rem     <= '0;
            idx     <= '0;
            r_val   <= '0;
            acc     <= '0;
            error   <= '0;
            err_vld <= 1'b0;
        end else begin
            err_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (go_ok) begin
                        acc <= '0;
                        if (pair_mask != '0) begin
                            idx   <= lowest_set(8'(pair_mask));
                            rem   <= pair_mask & (pair_mask - NUM_PAIRS'(1));
                            state <= SETTLE;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                SETTLE: if (tmr_exp) state <= CNV_R;
                CNV_R:  state <= WAIT_R;
                WAIT_R: begin
                    if (cnv_cmplt) begin
                        r_val <= A2D_res;
                        state <= CNV_L;
                    end
                end
                CNV_L:  state <= WAIT_L;
                WAIT_L: begin
                    if (cnv_cmplt) begin
                        acc   <= acc + (diff_ext <<< idx);
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (rem != '0) begin
                        idx   <= lowest_set(8'(rem));
                        rem   <= rem & (rem - NUM_PAIRS'(1));
                        state <= SETTLE;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    error   <= acc;
                    err_vld <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pair_active = (state == SETTLE) || (state == CNV_R) || (state == WAIT_R) ||
                         (state == CNV_L)  || (state == WAIT_L);
    assign left_side   = (state == CNV_L) || (state == WAIT_L);

    assign strt_cnv = (state == CNV_R) || (state == CNV_L);
    assign chnnl    = CH_W'({idx, left_side});
    assign ir_en    = pair_active ? (NUM_PAIRS'(1) << idx) : '0;
    assign busy     = (state != IDLE) || err_vld;

endmodule
